// File: rtl/updown_counter_8bit_pkg.sv
// ============================================================================
// updown_counter_8bit_pkg : shared width default and direction encodings
// Rev 1.0
// ============================================================================
`default_nettype none

package updown_counter_8bit_pkg;

  localparam int COUNTER_WIDTH = 8;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage : updown_counter_8bit_pkg

`default_nettype wire

// File: rtl/updown_counter_8bit.sv
// ============================================================================
// updown_counter_8bit : synchronous up/down counter with one-cycle wrap flag
// Rev 1.0
// ============================================================================
`default_nettype none

module updown_counter_8bit
  import updown_counter_8bit_pkg::*;
#(
  parameter int               WIDTH       = COUNTER_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             up_down,
  output logic [WIDTH-1:0] count,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_count;
  logic             r_overflow;

  logic [WIDTH-1:0] w_next_count;
  logic             w_at_max;
  logic             w_at_min;
  logic             w_wrap;

  assign w_at_max = &r_count;
  assign w_at_min = ~|r_count;

  // A wrap happens only on an enabled edge leaving the terminal value in the
  // current direction of travel.
  assign w_wrap = enable & (((up_down == DIR_UP)   & w_at_max) |
                            ((up_down == DIR_DOWN) & w_at_min));

  assign w_next_count = (up_down == DIR_UP) ? (r_count + c_one)
                                            : (r_count - c_one);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count    <= RESET_VALUE;
      r_overflow <= 1'b0;
    end else if (enable) begin
      r_count    <= w_next_count;
      r_overflow <= w_wrap;
    end else begin
      r_overflow <= 1'b0;
    end
  end

  assign count    = r_count;
  assign overflow = r_overflow;

endmodule : updown_counter_8bit

`default_nettype wire

// File: tb/tb_updown_counter_8bit.sv
// ============================================================================
// tb_updown_counter_8bit : directed + randomized check against an arithmetic model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_updown_counter_8bit;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       up_down;
  logic [7:0] count;
  logic       overflow;

  int n_cmp;
  int n_err;

  // Reference state: plain integers, modulo-256 arithmetic.
  int m_count;
  int m_ovf;

  updown_counter_8bit #(
    .WIDTH       (8),
    .RESET_VALUE (8'h00)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .up_down  (up_down),
    .count    (count),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    n_cmp++;
    if (observed !== expected) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Apply inputs at a falling edge, take one rising edge, update the model,
  // then compare at the next falling edge.
  task automatic step(input logic r, input logic en, input logic ud, input string tag);
    rst_n   = r;
    enable  = en;
    up_down = ud;
    @(posedge clk);
    if (!r) begin
      m_count = 0;
      m_ovf   = 0;
    end else if (en) begin
      if (ud) begin
        m_ovf   = (m_count == 255) ? 1 : 0;
        m_count = (m_count + 1) % 256;
      end else begin
        m_ovf   = (m_count == 0) ? 1 : 0;
        m_count = (m_count + 255) % 256;
      end
    end else begin
      m_ovf = 0;
    end
    @(negedge clk);
    check({tag, ".count"}, int'(count), m_count);
    check({tag, ".ovf"}, int'(overflow), m_ovf);
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    m_count = 0;
    m_ovf   = 0;
    rst_n   = 1'b0;
    enable  = 1'b0;
    up_down = 1'b1;
    @(negedge clk);

    step(1'b0, 1'b1, 1'b1, "reset_init");
    check("reset_init_const", int'(count), 0);

    // Climb to 0x37, then reset for two edges.
    for (int i = 0; i < 55; i++) step(1'b1, 1'b1, 1'b1, "climb");
    check("at_37", int'(count), 8'h37);
    // Reset asserted between edges must not act until a rising edge.
    rst_n = 1'b0;
    #2;
    check("no_async_reset", int'(count), 8'h37);
    step(1'b0, 1'b1, 1'b0, "reset_a");
    check("reset_a_const", int'(count), 0);
    step(1'b0, 1'b1, 1'b1, "reset_b");

    // Enable gating.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1, "up10");
    check("up10_const", int'(count), 8'h0A);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, "hold");
    check("hold_const", int'(count), 8'h0A);

    // Direction switching.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, "down10");
    check("down10_const", int'(count), 8'h00);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, "up3");
    step(1'b1, 1'b1, 1'b0, "down1");
    check("down1_const", int'(count), 8'h02);

    // Up wrap from 0xFD.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, "to_fd");
    check("at_fd", int'(count), 8'hFD);
    step(1'b1, 1'b1, 1'b1, "upw_fe");
    step(1'b1, 1'b1, 1'b1, "upw_ff");
    step(1'b1, 1'b1, 1'b1, "upw_00");
    check("upw_pulse", int'(overflow), 1);
    step(1'b1, 1'b1, 1'b1, "upw_01");
    check("upw_clear", int'(overflow), 0);

    // Down wrap from 0x01.
    step(1'b1, 1'b1, 1'b0, "dnw_00");
    step(1'b1, 1'b1, 1'b0, "dnw_ff");
    check("dnw_pulse", int'(overflow), 1);
    // Disabling while overflow is high clears it next edge.
    step(1'b1, 1'b0, 1'b0, "ovf_drop");
    check("ovf_drop_const", int'(overflow), 0);
    step(1'b1, 1'b1, 1'b0, "dnw_fe");

    // Reset mid-count from 0x80, then resume.
    for (int i = 0; i < 130; i++) step(1'b1, 1'b1, 1'b1, "to_80");
    check("at_80", int'(count), 8'h80);
    step(1'b0, 1'b1, 1'b1, "mid_reset");
    step(1'b1, 1'b1, 1'b1, "resume");
    check("resume_const", int'(count), 8'h01);

    // Randomized phase with occasional resets.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_updown_counter_8bit

`default_nettype wire
